// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM transfers, freezing the pipeline meanwhile.
// Define SRAM_WAIT_EN to stretch each half-access by WAIT_CYCLES hold cycles.
module sram_controller #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    inout  wire  [15:0] SRAM_DQ
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    typedef struct packed {
        logic        is_wr;
        logic [16:0] idx;
        logic [31:0] wdata;
    } req_t;

    state_t      state, state_nx;
    req_t        req_q;
    logic        req;
    logic        active;
    logic        half_last;
    logic [31:0] offset;
    logic [15:0] dq_out;

    assign req    = rd_en | wr_en;
    assign offset = address - ADDR_BASE;
    assign active = (state == LOW) || (state == HIGH);

`ifdef SRAM_WAIT_EN
    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES);

    logic [CW-1:0] wait_cnt;

    // Counts the cycles of the current half window; restarts at every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (active && !half_last)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    assign half_last = (wait_cnt == WAIT_LAST);
`else
    logic unused_wait;

    assign half_last   = 1'b1;
    assign unused_wait = (WAIT_CYCLES != 0);
`endif

    // Byte-lane bits and the upper offset bits fall outside the SRAM word space.
    logic [14:0] unused_offset;
    assign unused_offset = {offset[31:19], offset[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = LOW;
            LOW:     if (half_last) state_nx = HIGH;
            HIGH:    if (half_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Write wins when both enables are raised together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            req_q <= '0;
        else if (state == IDLE && req)
            req_q <= '{is_wr: wr_en, idx: offset[18:2], wdata: write_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            read_data <= '0;
        else if (!req_q.is_wr && half_last) begin
            if (state == LOW)
                read_data[15:0] <= SRAM_DQ;
            else if (state == HIGH)
                read_data[31:16] <= SRAM_DQ;
        end
    end

    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_out    = req_q.wdata[15:0];
        if (active) begin
            SRAM_ADDR = {req_q.idx, state == HIGH};
            SRAM_WE_N = !req_q.is_wr;
            if (state == HIGH)
                dq_out = req_q.wdata[31:16];
        end
    end

    assign SRAM_DQ = (active && req_q.is_wr) ? dq_out : 16'bz;
    assign ready   = ((state == IDLE) && !req) || (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural 16-bit SRAM on the bus.
module tb_sram_controller;

`ifdef SRAM_WAIT_EN
    localparam int          EXP_LOW = 7;
    localparam logic [15:0] EXP_WE  = 16'h007E;
`else
    localparam int          EXP_LOW = 3;
    localparam logic [15:0] EXP_WE  = 16'h0006;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    wire  [15:0] SRAM_DQ;

    logic [15:0] mem [16];

    int pass_cnt  = 0;
    int total_cnt = 0;

    sram_controller #(.ADDR_BASE(32'd1024), .WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .ready     (ready),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_DQ   (SRAM_DQ)
    );

    always #5 clk = ~clk;

    // Asynchronous-read SRAM without output enable: drives whenever not strobed.
    assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR[3:0]] : 16'bz;

    always @(posedge clk)
        if (!SRAM_WE_N) mem[SRAM_ADDR[3:0]] <= SRAM_DQ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues a request at a negedge and returns #1 into the ready cycle.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                          output int lowc, output logic [15:0] mask, output logic [17:0] addr1);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        lowc = 0; mask = '0; addr1 = '0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!SRAM_WE_N && k < 16) mask[k] = 1'b1;
            if (k == 1) addr1 = SRAM_ADDR;
            if (ready) break;
            lowc++;
            @(negedge clk);
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lowc;
        logic [15:0] mask;
        logic [17:0] a1;

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd1024; write_data = '0;
        @(negedge clk); #1;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_we_n", {31'h0, SRAM_WE_N}, 32'h1);
        chk("rst_addr", {14'h0, SRAM_ADDR}, 32'h0);
        chk("rst_ready_idle", {31'h0, ready}, 32'h1);
        rd_en = 1'b1; #1;
        chk("rst_ready_req", {31'h0, ready}, 32'h0);
        rd_en = 1'b0;
        @(negedge clk); rst = 1'b0;

        // Store at base address
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lowc, mask, a1);
        chk("st0_ready_low", lowc, EXP_LOW);
        chk("st0_we_mask", {16'h0, mask}, {16'h0, EXP_WE});
        chk("st0_mem0", {16'h0, mem[0]}, 32'h0000BEEF);
        chk("st0_mem1", {16'h0, mem[1]}, 32'h0000DEAD);

        release_req();
        access(1'b0, 1'b1, 32'd1024, 32'h0, lowc, mask, a1);
        chk("ld0_ready_low", lowc, EXP_LOW);
        chk("ld0_we_mask", {16'h0, mask}, 32'h0);
        chk("ld0_data", read_data, 32'hDEADBEEF);

        // Offset address
        release_req();
        access(1'b1, 1'b0, 32'd1028, 32'h12345678, lowc, mask, a1);
        chk("st1_addr_low", {14'h0, a1}, 32'h2);
        chk("st1_mem2", {16'h0, mem[2]}, 32'h00005678);
        chk("st1_mem3", {16'h0, mem[3]}, 32'h00001234);
        release_req();
        access(1'b0, 1'b1, 32'd1024, 32'h0, lowc, mask, a1);
        chk("ld1_data", read_data, 32'hDEADBEEF);
        release_req();
        access(1'b0, 1'b1, 32'd1028, 32'h0, lowc, mask, a1);
        chk("ld2_data", read_data, 32'h12345678);

        // Both enables: write wins
        release_req();
        access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, lowc, mask, a1);
        chk("both_we_mask", {16'h0, mask}, {16'h0, EXP_WE});
        chk("both_mem4", {16'h0, mem[4]}, 32'h0000F00D);
        chk("both_mem5", {16'h0, mem[5]}, 32'h0000CAFE);
        chk("both_read_data", read_data, 32'h12345678);

        // Reset during the last half of a load
        release_req();
        wr_en = 1'b0; rd_en = 1'b1; address = 32'd1028;
        repeat (EXP_LOW - 1) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_read_data", read_data, 32'h0);
        chk("mid_rst_we_n", {31'h0, SRAM_WE_N}, 32'h1);
        chk("mid_rst_addr", {14'h0, SRAM_ADDR}, 32'h0);
        chk("mid_rst_ready", {31'h0, ready}, 32'h0);
        @(negedge clk); rst = 1'b0;
        access(1'b0, 1'b1, 32'd1028, 32'h0, lowc, mask, a1);
        chk("restart_ready_low", lowc, EXP_LOW);
        chk("restart_data", read_data, 32'h12345678);

        // Pattern store and readback
        release_req();
        access(1'b1, 1'b0, 32'd1024, 32'hA5A55A5A, lowc, mask, a1);
        chk("st2_ready_low", lowc, EXP_LOW);
        chk("st2_we_mask", {16'h0, mask}, {16'h0, EXP_WE});
        release_req();
        access(1'b0, 1'b1, 32'd1024, 32'h0, lowc, mask, a1);
        chk("ld3_data", read_data, 32'hA5A55A5A);
        chk("ld3_ready_low", lowc, EXP_LOW);
        release_req();

        @(negedge clk); #1;
        chk("idle_ready", {31'h0, ready}, 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences 32-bit load/store requests from the MEM stage onto the 16-bit external SRAM by splitting each access into a low-half and a high-half transfer. Drives the SRAM address, write-enable and bidirectional data bus, and holds `ready` low so the pipeline freezes while an access is in flight. Sits between the MEM stage and the SRAM; it is the only master of the SRAM bus.

## Interface
Parameters:
- `ADDR_BASE`, 1024: byte address mapped to SRAM entry 0.
- `WAIT_CYCLES`, 2: extra hold cycles per half-access. Used only when `SRAM_WAIT_EN` is defined.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: store request; held stable until `ready`=1.
- `rd_en` in 1: load request; held stable until `ready`=1.
- `address` in 32: byte address, word aligned.
- `write_data` in 32: store data.
- `read_data` out 32: load result; registered.
- `ready` out 1: 0 = freeze the pipeline.
- `SRAM_ADDR` out 18: SRAM entry index.
- `SRAM_WE_N` out 1: active-low write strobe.
- `SRAM_DQ` inout 16: data bus; driven only during write halves, otherwise `16'bz`.

## Operation
- Word index `w = (address - ADDR_BASE) >> 2`, 32-bit subtract, low 17 bits kept.
- Low half maps to `SRAM_ADDR = {w[16:0],1'b0}`; high half maps to `{w[16:0],1'b1}`.
- States:
  - IDLE → LOW when `rd_en|wr_en`.
  - LOW → HIGH.
  - HIGH → DONE.
  - DONE → IDLE unconditionally.
- Operation type is latched on the IDLE→LOW edge. If `wr_en` and `rd_en` are both high, the access is a write.
- IDLE and DONE:
  - `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_DQ`=Z.
- LOW:
  - Write: `SRAM_WE_N`=0, DQ=`write_data[15:0]`.
  - Read: `SRAM_WE_N`=1; `read_data[15:0]` ← DQ on the leaving edge.
- HIGH:
  - Same as LOW, but with `write_data[31:16]`, and `read_data[31:16]` is captured.
- `ready` is combinational: `(IDLE & ~(rd_en|wr_en)) | DONE`.
- The pipeline advances on the edge ending DONE. Any request seen in IDLE afterwards is therefore a new request.
- Writes do not modify `read_data`.
- All `SRAM_*` outputs are combinational from the state and latched request, so the SRAM samples its write on the edge that ends LOW or HIGH.

## Timing
- Reset values:
  - State IDLE, `read_data`=0, `SRAM_WE_N`=1, `SRAM_ADDR`=0, `SRAM_DQ`=Z.
  - `ready` = `~(rd_en|wr_en)`.
- Latency, without the macro:
  - Request first seen in cycle 0 (IDLE).
  - LOW in cycle 1, HIGH in cycle 2, DONE in cycle 3.
  - `ready` is low for cycles 0–2 and high in cycle 3. `read_data` is valid in cycle 3.
- Back-to-back requests: every request costs 4 cycles. There is one dead IDLE cycle after DONE.
- `rst` asserted mid-access:
  - Immediate return to IDLE, with `SRAM_WE_N` forced to 1 and the bus released asynchronously.
  - `read_data` clears to 0.
  - A half-write already strobed stays in the SRAM.
- Requests are assumed word aligned; `address[1:0]` is ignored.

## Configuration
- `SRAM_WAIT_EN` defined:
  - LOW and HIGH each last `1+WAIT_CYCLES` cycles, counted by an internal counter.
  - `SRAM_WE_N`, `SRAM_ADDR` and DQ are held stable for the whole window.
  - Read data is captured only on the final cycle of each window.
  - With `WAIT_CYCLES`=2: `ready` is low for 7 cycles; DONE is in cycle 7.
- `SRAM_WAIT_EN` undefined:
  - One cycle per half. No counter is instantiated and `WAIT_CYCLES` is unused.

## Test plan
- Store, base address:
  - Stimulus: `wr_en`=1, `address`=1024, `write_data`=0xDEADBEEF.
  - Response: SRAM[0]=0xBEEF and SRAM[1]=0xDEAD; `ready` low exactly 3 cycles; `SRAM_WE_N` low only in cycles 1 and 2.
- Read back:
  - Stimulus: `rd_en`=1, `address`=1024.
  - Response: `read_data`=0xDEADBEEF in the `ready` cycle; DQ never driven by the controller.
- Offset address:
  - Stimulus: store 0x12345678 at 1028, then load 1024 and load 1028.
  - Response: loads return 0xDEADBEEF and 0x12345678; SRAM[2]=0x5678, SRAM[3]=0x1234.
- Both enables high:
  - Stimulus: `rd_en`=`wr_en`=1, `address`=1032, `write_data`=0xCAFEF00D.
  - Response: treated as a write (SRAM[4]=0xF00D, SRAM[5]=0xCAFE); `read_data` unchanged.
- Reset mid-access:
  - Stimulus: `rst` pulsed during HIGH of a load.
  - Response: `read_data`=0, `SRAM_WE_N`=1, DQ=Z immediately. With the request still held, `ready` stays 0 and a full 4-cycle access restarts after `rst` falls.
- Wait states:
  - Stimulus: `SRAM_WAIT_EN` defined, `WAIT_CYCLES`=2; store 0xA5A55A5A at 1024.
  - Response: `ready` low 7 cycles; `SRAM_WE_N` low for 3 consecutive cycles per half; readback returns 0xA5A55A5A.
